// File: rtl/display_scan_ctrl_pkg.sv
// Shared segment patterns and default sizing for the multiplexed 7-segment scanner.
// Segment vectors are [0:6] = a..g, active-low (0 = lit).
package display_scan_ctrl_pkg;

    localparam int N_DIGITOS_DEF     = 4;
    localparam int DIV_VARREDURA_DEF = 50000;

    localparam logic [0:6] SEG_0       = 7'b0000001;
    localparam logic [0:6] SEG_1       = 7'b1001111;
    localparam logic [0:6] SEG_2       = 7'b0010010;
    localparam logic [0:6] SEG_3       = 7'b0000110;
    localparam logic [0:6] SEG_4       = 7'b1001100;
    localparam logic [0:6] SEG_5       = 7'b0100100;
    localparam logic [0:6] SEG_6       = 7'b0100000;
    localparam logic [0:6] SEG_7       = 7'b0001111;
    localparam logic [0:6] SEG_8       = 7'b0000000;
    localparam logic [0:6] SEG_9       = 7'b0000100;
    localparam logic [0:6] SEG_ERRO    = 7'b0110000;
    localparam logic [0:6] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/display_scan_ctrl_seg7_decod.sv
// Combinational BCD to 7-segment decoder; non-BCD codes render an "E".
module seg7_decod
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [0:6] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_ERRO;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous value updates.
// Optional macro DISPLAY_SCAN_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITOS     = N_DIGITOS_DEF,
    parameter int DIV_VARREDURA = DIV_VARREDURA_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4*N_DIGITOS-1:0] valor,
    input  logic                   carga,
    output logic                   pendente,
    output logic [N_DIGITOS-1:0]   anodo,
    output logic [0:6]             segmentos
);

    localparam int IW = $clog2(N_DIGITOS);
    localparam int CW = $clog2(DIV_VARREDURA);
    localparam logic [IW-1:0]        IDX_LAST = IW'(N_DIGITOS - 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DIV_VARREDURA - 1);
    localparam logic [N_DIGITOS-1:0] ONE_HOT0 = {{(N_DIGITOS-1){1'b0}}, 1'b1};

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*N_DIGITOS-1:0] buf_q, buf_d;
    logic [4*N_DIGITOS-1:0] disp_q, disp_d;
    logic                   pend_q, pend_d;
    logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
    logic [0:6]             seg_q, seg_d;

    logic       tick;
    logic       frameEnd;
    logic [3:0] digitSel;
    logic [0:6] digitSeg;

    assign tick     = (cnt_q == CNT_LAST);
    assign frameEnd = tick && (idx_q == IDX_LAST);
    assign digitSel = disp_q[{idx_q, 2'b00} +: 4];

    seg7_decod u_decod (
        .bcd_i (digitSel),
        .seg_o (digitSeg)
    );

    // A load on the frame-end cycle bypasses the buffer; otherwise it waits there.
    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        buf_d  = buf_q;
        disp_d = disp_q;
        pend_d = pend_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frameEnd) begin
            if (carga) begin
                disp_d = valor;
            end else if (pend_q) begin
                disp_d = buf_q;
            end
            pend_d = 1'b0;
        end else if (carga) begin
            buf_d  = valor;
            pend_d = 1'b1;
        end
    end

`ifdef DISPLAY_SCAN_ZERO_BLANK_EN
    logic [IW-1:0] msdIdx;

    always_comb begin
        msdIdx = '0;
        for (int k = 1; k < N_DIGITOS; k++) begin
            if (disp_q[4*k +: 4] != 4'd0) begin
                msdIdx = IW'(k);
            end
        end
        anodo_d = ~(ONE_HOT0 << idx_q);
        seg_d   = (idx_q > msdIdx) ? SEG_APAGADO : digitSeg;
    end
`else
    always_comb begin
        anodo_d = ~(ONE_HOT0 << idx_q);
        seg_d   = digitSeg;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            disp_q  <= '0;
            pend_q  <= 1'b0;
            anodo_q <= '1;
            seg_q   <= SEG_APAGADO;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            anodo_q <= anodo_d;
            seg_q   <= seg_d;
        end
    end

    assign pendente  = pend_q;
    assign anodo     = anodo_q;
    assign segmentos = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a cycle-count based model.
// Honours DISPLAY_SCAN_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_display_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b0;
    logic            carga   = 1'b0;
    logic [4*N-1:0]  valor   = '0;
    logic            pendente;
    logic [N-1:0]    anodo;
    logic [0:6]      segmentos;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release, shown value, waiting value.
    int              edgeNum = 0;
    logic [4*N-1:0]  mDisp   = '0;
    logic [4*N-1:0]  mBuf    = '0;
    logic            mPend   = 1'b0;

    display_scan_ctrl #(
        .N_DIGITOS     (N),
        .DIV_VARREDURA (DIV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .valor     (valor),
        .carga     (carga),
        .pendente  (pendente),
        .anodo     (anodo),
        .segmentos (segmentos)
    );

    always #5 clock = ~clock;

    task automatic checkResult(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0b expected=%0b at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] segOf(input logic [3:0] d);
        logic [0:6] table10 [10];
        table10 = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        if (d > 4'd9) return 7'b0110000;
        return table10[d];
    endfunction

    function automatic int highestNonzero(input logic [4*N-1:0] v);
        int h = 0;
        for (int k = 0; k < N; k++) begin
            if (((v >> (4*k)) & 16'hF) != 0) h = k;
        end
        return h;
    endfunction

    // One clock: drive inputs, advance the model, check outputs #1 after the edge.
    task automatic applyStimulus(input logic c, input logic [4*N-1:0] v);
        int          shownIdx;
        logic [3:0]  digit;
        logic [0:6]  expSeg;
        logic [N-1:0] expAn;
        logic [4*N-1:0] shownVal;
        carga = c;
        valor = v;
        @(posedge clock);
        edgeNum++;
        shownIdx = ((edgeNum - 1) / DIV) % N;
        shownVal = mDisp;
        if (edgeNum % (DIV * N) == 0) begin
            if (c) mDisp = v;
            else if (mPend) mDisp = mBuf;
            mPend = 1'b0;
        end else if (c) begin
            mBuf  = v;
            mPend = 1'b1;
        end
        digit  = 4'((shownVal >> (4*shownIdx)) & 16'hF);
        expSeg = segOf(digit);
`ifdef DISPLAY_SCAN_ZERO_BLANK_EN
        if (shownIdx > highestNonzero(shownVal)) expSeg = 7'b1111111;
`endif
        expAn = ~(N'(1) << shownIdx);
        #1;
        checkResult("anodo", 32'(anodo), 32'(expAn));
        checkResult("segmentos", 32'(segmentos), 32'(expSeg));
        checkResult("pendente", 32'(pendente), 32'(mPend));
    endtask

    task automatic idleSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, valor);
    endtask

    task automatic waitForBoundaryNext();
        for (int i = 0; i < DIV * N && ((edgeNum + 1) % (DIV * N)) != 0; i++) applyStimulus(1'b0, valor);
    endtask

    function automatic logic [4*N-1:0] randomValue();
        logic [4*N-1:0] v;
        for (int k = 0; k < N; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 3) == 0) v[4*N-1 -: 8] = '0;
        return v;
    endfunction

    initial begin
        #12;
        checkResult("reset_anodo", 32'(anodo), 32'({N{1'b1}}));
        checkResult("reset_seg", 32'(segmentos), 32'(7'b1111111));
        checkResult("reset_pend", 32'(pendente), 32'(1'b0));
        reset_n = 1'b1;

        idleSteps(20);

        applyStimulus(1'b1, 16'h1234);
        idleSteps(30);

        waitForBoundaryNext();
        idleSteps(3);
        applyStimulus(1'b1, 16'h1111);
        idleSteps(2);
        applyStimulus(1'b1, 16'h5678);
        idleSteps(24);

        waitForBoundaryNext();
        applyStimulus(1'b1, 16'h0009);
        idleSteps(18);

        applyStimulus(1'b1, 16'h00A7);
        idleSteps(34);
        applyStimulus(1'b1, 16'h0050);
        idleSteps(34);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) applyStimulus(1'b1, randomValue());
            else applyStimulus(1'b0, randomValue());
        end

        waitForBoundaryNext();
        idleSteps(5);
        applyStimulus(1'b1, 16'h4321);
        idleSteps(2);
        #2;
        reset_n = 1'b0;
        #1;
        checkResult("async_anodo", 32'(anodo), 32'({N{1'b1}}));
        checkResult("async_seg", 32'(segmentos), 32'(7'b1111111));
        checkResult("async_pend", 32'(pendente), 32'(1'b0));
        edgeNum = 0;
        mDisp   = '0;
        mBuf    = '0;
        mPend   = 1'b0;
        carga   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idleSteps(40);

        carga = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
